// File: rtl/hex_display_bank.sv
// N-digit active-low 7-segment driver with a registered hex value, byte shift-in and per-digit blink.
// Optional leading-zero blanking is compiled in when HEX_LZ_BLANK_EN is defined.
module hex_display_bank #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    shift,
  input  logic [7:0]              byte_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic                    blink_phase,
  output logic [7*NUM_DIGITS-1:0] HEX_out
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [4*NUM_DIGITS-1:0] value_reg;
  logic [4*NUM_DIGITS-1:0] value_next;
  logic [4*NUM_DIGITS-1:0] shift_val;
  logic [CNT_W-1:0]        blink_cnt_reg;
  logic                    phase_reg;
  logic [7*NUM_DIGITS-1:0] hex_reg;
  logic [7*NUM_DIGITS-1:0] hex_next;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // With only two digits a shifted-in byte replaces the whole value.
  generate
    if (NUM_DIGITS == 2) begin : g_shift_narrow
      assign shift_val = byte_in;
    end else begin : g_shift_wide
      assign shift_val = {value_reg[4*NUM_DIGITS-9:0], byte_in};
    end
  endgenerate

  always_comb begin
    value_next = value_reg;
    if (clear)      value_next = '0;
    else if (load)  value_next = data_in;
    else if (shift) value_next = shift_val;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic blank_d;
`ifdef HEX_LZ_BLANK_EN
      // Digit 0 is never leading-zero blanked so a zero value still reads "0".
      assign blank_d = ((gi != 0) && (value_reg[4*NUM_DIGITS-1:4*gi] == '0))
                       || (phase_reg && blink_mask[gi]);
`else
      assign blank_d = phase_reg && blink_mask[gi];
`endif
      assign hex_next[7*gi +: 7] = blank_d ? 7'b1111111 : seg7(value_reg[4*gi +: 4]);
    end
  endgenerate

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      value_reg     <= '0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      hex_reg       <= '1;
    end else begin
      value_reg <= value_next;
      hex_reg   <= hex_next;
      if (blink_cnt_reg == CNT_W'(BLINK_DIV - 1)) begin
        blink_cnt_reg <= '0;
        phase_reg     <= ~phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  assign value_out   = value_reg;
  assign blink_phase = phase_reg;
  assign HEX_out     = hex_reg;

endmodule
